// File: rtl/seq_det_arb_if.sv
// Request/grant and detection bundle for seq_det_arb.
// det_cnt exists only when SEQ_DET_ARB_CNT_EN is defined.
interface seq_det_arb_if;
  logic [3:0]  req;
  logic [3:0]  bit_in;
  logic [3:0]  clr;
  logic [3:0]  gnt;
  logic        det_vld;
  logic [1:0]  det_ch;
`ifdef SEQ_DET_ARB_CNT_EN
  logic [31:0] det_cnt;

  modport master (
    output req, bit_in, clr,
    input  gnt, det_vld, det_ch, det_cnt
  );
  modport slave (
    input  req, bit_in, clr,
    output gnt, det_vld, det_ch, det_cnt
  );
`else
  modport master (
    output req, bit_in, clr,
    input  gnt, det_vld, det_ch
  );
  modport slave (
    input  req, bit_in, clr,
    output gnt, det_vld, det_ch
  );
`endif
endinterface

// File: rtl/seq_det_arb.sv
// Shared 4-bit sequence detector time-multiplexed over 4 channels by a
// round-robin arbiter; SEQ_DET_ARB_CNT_EN adds per-channel hit counters.
module seq_det_arb #(
  parameter logic [3:0] PATTERN = 4'b1001
) (
  input logic          clk,
  input logic          rst,
  seq_det_arb_if.slave bus
);
  logic [1:0] ptr;
  logic [3:0] hist [4];
  logic [2:0] fill [4];

  logic [3:0] grant;
  logic       hit;
  logic [1:0] gidx;
  logic [1:0] idx;
  logic [3:0] nh;
  logic [2:0] nf;
  logic       match;

  logic       det_vld;
  logic [1:0] det_ch;

  // First requester at or after ptr, wrapping modulo 4
  always_comb begin
    grant = '0;
    hit   = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        gidx = idx;
      end
    end
    if (hit)
      grant[gidx] = 1'b1;
  end

  // A clear in the grant cycle restarts the context with the new bit
  always_comb begin
    nh    = '0;
    nf    = '0;
    match = 1'b0;
    if (bus.clr[gidx]) begin
      nh = {3'b000, bus.bit_in[gidx]};
      nf = 3'd1;
    end else begin
      nh = {hist[gidx][2:0], bus.bit_in[gidx]};
      nf = (fill[gidx] == 3'd4) ? 3'd4 : fill[gidx] + 3'd1;
    end
    match = hit && !bus.clr[gidx] &&
            (nf == 3'd4) && (nh == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      det_vld <= 1'b0;
      det_ch  <= '0;
      for (int k = 0; k < 4; k++) begin
        hist[k] <= '0;
        fill[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.clr[k]) begin
          hist[k] <= '0;
          fill[k] <= '0;
        end
      end
      if (hit) begin
        ptr        <= gidx + 2'd1;
        hist[gidx] <= nh;
        fill[gidx] <= nf;
      end
      det_vld <= match;
      if (match)
        det_ch <= gidx;
    end
  end

  assign bus.gnt     = grant;
  assign bus.det_vld = det_vld;
  assign bus.det_ch  = det_ch;

`ifdef SEQ_DET_ARB_CNT_EN
  logic [7:0] cnt [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++)
        cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bus.clr[k])
          cnt[k] <= '0;
        else if (match && gidx == 2'(k) && cnt[k] != 8'hff)
          cnt[k] <= cnt[k] + 8'd1;
      end
    end
  end

  assign bus.det_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif
endmodule
